// File: rtl/rom_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the boot ROM.
// Writes are refused with err; a BUSY cycle the ROM never acks is aborted with err.
module rom_wb_arbiter #(
  parameter int AW      = 13,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [AW+1:2] m0_adr_i,
  input  logic [3:0]    m0_sel_i,
  input  logic [DW-1:0] m0_dat_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [AW+1:2] m1_adr_i,
  input  logic [3:0]    m1_sel_i,
  input  logic [DW-1:0] m1_dat_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [AW+1:2] s_adr_o,
  output logic [3:0]    s_sel_o,
  output logic [DW-1:0] s_dat_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i
);

  typedef enum logic [2:0] {IDLE, BUSY0, BUSY1, ERR0, ERR1} state_t;

  state_t     state;
  logic       last_grant;
  logic [7:0] cnt;

  logic req0, req1, busy, sel1, breq, tmo, timeout_now;

  assign req0        = m0_cyc_i & m0_stb_i;
  assign req1        = m1_cyc_i & m1_stb_i;
  assign busy        = (state == BUSY0) || (state == BUSY1);
  assign sel1        = (state == BUSY1);
  assign breq        = sel1 ? req1 : req0;
  assign tmo         = (cnt == 8'(TIMEOUT - 1));
  // A slave ack in the final counted cycle takes precedence over the timeout.
  assign timeout_now = busy & breq & ~s_ack_i & tmo;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req0 && (!req1 || last_grant)) begin
            state <= m0_we_i ? ERR0 : BUSY0;
          end else if (req1) begin
            state <= m1_we_i ? ERR1 : BUSY1;
          end
        end
        BUSY0, BUSY1: begin
          if (!breq) begin
            state <= IDLE;
          end else if (s_ack_i || tmo) begin
            state      <= IDLE;
            last_grant <= sel1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ERR0: begin
          state      <= IDLE;
          last_grant <= 1'b0;
        end
        ERR1: begin
          state      <= IDLE;
          last_grant <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_sel_o  = '0;
    s_dat_o  = '0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;

    // The bus is only driven while the granted master still requests.
    if (busy && breq) begin
      s_cyc_o = ~timeout_now;
      s_stb_o = ~timeout_now;
      s_we_o  = sel1 ? m1_we_i  : m0_we_i;
      s_adr_o = sel1 ? m1_adr_i : m0_adr_i;
      s_sel_o = sel1 ? m1_sel_i : m0_sel_i;
      s_dat_o = sel1 ? m1_dat_i : m0_dat_i;
    end

    case (state)
      BUSY0: begin
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i & req0;
        m0_err_o = timeout_now;
      end
      BUSY1: begin
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i & req1;
        m1_err_o = timeout_now;
      end
      ERR0:    m0_err_o = req0;
      ERR1:    m1_err_o = req1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rom_wb_arbiter.sv
// Bench for rom_wb_arbiter: registered-ack ROM model, per-master scoreboards
// and cycle-accurate directed scenarios.
module tb_rom_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [14:2] m0_adr, m1_adr, s_adr;
  logic [3:0]  m0_sel, m1_sel, s_sel;
  logic [31:0] m0_wdat, m1_wdat, m0_dat, m1_dat, s_dat, rom_dat;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we, rom_ack, ack_en;

  typedef struct {
    logic        err;
    logic [31:0] dat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   term_m[$];
  int   term_t[$];
  int   cyc_cnt = 0;
  int   checks  = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  rom_wb_arbiter #(.AW(13), .DW(32), .TIMEOUT(15)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_sel_i(m0_sel), .m0_dat_i(m0_wdat), .m0_dat_o(m0_dat),
    .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_sel_i(m1_sel), .m1_dat_i(m1_wdat), .m1_dat_o(m1_dat),
    .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
    .s_sel_o(s_sel), .s_dat_o(s_dat), .s_dat_i(rom_dat), .s_ack_i(rom_ack)
  );

  function automatic logic [31:0] rom_word(input logic [14:2] a);
    return (a == 13'd1) ? 32'h0000_0093 : {16'hC0DE, 3'b000, a};
  endfunction

  // ROM slave: toggled registered ack, ack_en lets a scenario starve the arbiter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rom_ack <= 1'b0;
      rom_dat <= '0;
    end else begin
      rom_ack <= ack_en & s_cyc & s_stb & ~rom_ack;
      rom_dat <= rom_word(s_adr);
    end
  end

  always @(posedge clk) cyc_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (m0_ack | m0_err | m1_ack | m1_err) begin
      check("sb_overlap", {63'd0, (m0_ack | m0_err) & (m1_ack | m1_err)}, 64'd0);
    end
    if (m0_ack | m0_err) begin
      check("sb_m0_excl", {63'd0, m0_ack & m0_err}, 64'd0);
      if (q0.size() == 0) begin
        check("sb_m0_unexpected", 64'd1, 64'd0);
      end else begin
        e = q0.pop_front();
        check("sb_m0_kind", {63'd0, m0_err}, {63'd0, e.err});
        if (!e.err) check("sb_m0_dat", {32'd0, m0_dat}, {32'd0, e.dat});
        term_m.push_back(0);
        term_t.push_back(cyc_cnt);
      end
    end
    if (m1_ack | m1_err) begin
      check("sb_m1_excl", {63'd0, m1_ack & m1_err}, 64'd0);
      if (q1.size() == 0) begin
        check("sb_m1_unexpected", 64'd1, 64'd0);
      end else begin
        e = q1.pop_front();
        check("sb_m1_kind", {63'd0, m1_err}, {63'd0, e.err});
        if (!e.err) check("sb_m1_dat", {32'd0, m1_dat}, {32'd0, e.dat});
        term_m.push_back(1);
        term_t.push_back(cyc_cnt);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic req, input logic we,
                       input logic [14:2] adr, input logic [31:0] dat);
    if (k == 0) begin
      m0_cyc = req; m0_stb = req; m0_we = we; m0_adr = adr; m0_wdat = dat; m0_sel = 4'hF;
    end else begin
      m1_cyc = req; m1_stb = req; m1_we = we; m1_adr = adr; m1_wdat = dat; m1_sel = 4'hF;
    end
  endtask

  task automatic push_exp(input int k, input logic err, input logic [31:0] dat);
    exp_t e;
    e.err = err;
    e.dat = dat;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {57'd0, m0_ack, m0_err, m1_ack, m1_err, s_cyc, s_stb, s_we}, 64'd0);
    check({tag, "_bus"}, {47'd0, s_adr, s_sel}, 64'd0);
    check({tag, "_sdat"}, {32'd0, s_dat}, 64'd0);
    check({tag, "_mdat"}, {m0_dat, m1_dat}, 64'd0);
  endtask

  // Called just after a rising edge; holds the request across n back-to-back reads.
  task automatic run_master(input int k, input int n, input logic [14:2] base);
    logic got;
    for (int i = 0; i < n; i++) begin
      drive(k, 1'b1, 1'b0, base + 13'(i), 32'd0);
      push_exp(k, 1'b0, rom_word(base + 13'(i)));
      got = 1'b0;
      for (int c = 0; c < 50 && !got; c++) begin
        @(negedge clk);
        got = (k == 0) ? (m0_ack | m0_err) : (m1_ack | m1_err);
      end
      if (!got) check("rr_wait_bound", 64'd0, 64'd1);
      tick();
    end
    drive(k, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    int bad;
    rst_n  = 1'b0;
    ack_en = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    tick();
    rst_n = 1'b1;

    // Single m0 read of ROM word 1
    tick();
    drive(0, 1'b1, 1'b0, 13'd1, 32'd0);
    push_exp(0, 1'b0, 32'h0000_0093);
    @(negedge clk); check("t1_c0_stb", {63'd0, s_stb}, 64'd0);
    tick(); @(negedge clk);
    check("t1_c1_stb", {63'd0, s_stb}, 64'd1);
    check("t1_c1_adr", {51'd0, s_adr}, 64'd1);
    tick(); @(negedge clk);
    check("t1_c2_ack", {63'd0, m0_ack}, 64'd1);
    check("t1_c2_dat", {32'd0, m0_dat}, 64'h93);
    tick(); drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk); check("t1_c3_idle", {62'd0, s_cyc, m0_ack}, 64'd0);

    // m1 write is refused locally
    tick();
    drive(1, 1'b1, 1'b1, 13'h004, 32'hDEAD_BEEF);
    push_exp(1, 1'b1, 32'd0);
    @(negedge clk); check("t3_c0_cyc", {63'd0, s_cyc}, 64'd0);
    tick(); @(negedge clk);
    check("t3_c1_err", {63'd0, m1_err}, 64'd1);
    check("t3_c1_ack", {63'd0, m1_ack}, 64'd0);
    check("t3_c1_cyc", {63'd0, s_cyc}, 64'd0);
    tick(); @(negedge clk);
    check("t3_c2_err", {62'd0, m1_err, s_cyc}, 64'd0);
    #1 drive(1, 1'b0, 1'b0, '0, '0);

    // Timeout: ROM never acks, m1 queues up behind m0
    ack_en = 1'b0;
    tick();
    drive(0, 1'b1, 1'b0, 13'd2, 32'd0);
    push_exp(0, 1'b1, 32'd0);
    bad = 0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 2) begin
        drive(1, 1'b1, 1'b0, 13'd3, 32'd0);
        push_exp(1, 1'b0, rom_word(13'd3));
      end
      @(negedge clk);
      if (s_cyc !== 1'b1 || m0_err !== 1'b0) bad++;
    end
    check("t4_busy_hold", 64'(bad), 64'd0);
    tick(); @(negedge clk);
    check("t4_err", {63'd0, m0_err}, 64'd1);
    check("t4_cyc", {62'd0, s_cyc, s_stb}, 64'd0);
    tick(); drive(0, 1'b0, 1'b0, '0, '0); ack_en = 1'b1;
    @(negedge clk); check("t4_idle", {63'd0, s_cyc}, 64'd0);
    tick(); @(negedge clk); check("t4_m1_grant", {50'd0, s_stb, s_adr}, {50'd0, 1'b1, 13'd3});
    tick(); @(negedge clk); check("t4_m1_ack", {63'd0, m1_ack}, 64'd1);
    tick(); drive(1, 1'b0, 1'b0, '0, '0);

    // m0 abandons its cycle before the ack; pending m1 is served next
    tick();
    drive(0, 1'b1, 1'b0, 13'd5, 32'd0);
    drive(1, 1'b1, 1'b0, 13'd6, 32'd0);
    push_exp(1, 1'b0, rom_word(13'd6));
    tick(); drive(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("t5_abort_cyc", {62'd0, s_cyc, s_stb}, 64'd0);
    check("t5_abort_term", {62'd0, m0_ack, m0_err}, 64'd0);
    tick(); @(negedge clk); check("t5_idle", {63'd0, s_cyc}, 64'd0);
    tick(); @(negedge clk); check("t5_m1_grant", {50'd0, s_stb, s_adr}, {50'd0, 1'b1, 13'd6});
    tick(); @(negedge clk); check("t5_m1_ack", {63'd0, m1_ack}, 64'd1);
    tick(); drive(1, 1'b0, 1'b0, '0, '0);

    // Reset lands in the middle of BUSY1
    tick();
    drive(1, 1'b1, 1'b0, 13'd7, 32'd0);
    tick(); @(negedge clk); check("t6_busy1", {63'd0, s_stb}, 64'd1);
    #1 rst_n = 1'b0;
    tick(); @(negedge clk);
    check_reset_outputs("t6_rst");
    #1 drive(1, 1'b0, 1'b0, '0, '0);
    tick(); tick();
    rst_n = 1'b1;

    // Both masters request continuously: strict alternation starting with m0
    tick();
    term_m.delete();
    term_t.delete();
    fork
      run_master(0, 2, 13'd8);
      run_master(1, 2, 13'd16);
    join
    check("rr_count", 64'(term_m.size()), 64'd4);
    if (term_m.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("rr_order", 64'(term_m[i]), 64'(i % 2));
        if (i > 0) check("rr_spacing", 64'(term_t[i] - term_t[i-1]), 64'd3);
      end
    end

    tick(); tick();
    check("q0_drained", 64'(q0.size()), 64'd0);
    check("q1_drained", 64'(q1.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rom_wb_arbiter.md
Name: rom_wb_arbiter

Overview:
Two-master, one-slave Wishbone arbiter that shares the boot ROM between the instruction-fetch port (m0) and the data/load port (m1). It grants round-robin and holds the grant until the ROM terminates the cycle. Writes are rejected locally with an error termination, and a timeout aborts any cycle the ROM never acknowledges. It sits between the core's bus interfaces and the ROM's 32-bit Wishbone slave port, which uses a registered (delayed) acknowledge.

Parameters:
AW, 13, word-address width; the address bus is adr[AW+1:2] (byte address bits 14:2 at default).
DW, 32, data width.
TIMEOUT, 15, cycles in BUSY without slave ack before the arbiter aborts with err (range 2..255).

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  fetch-master cycle, strobe, write enable
m0_adr_i  in  AW  fetch-master word address
m0_sel_i  in  4  fetch-master byte selects
m0_dat_i  in  DW  fetch-master write data
m0_dat_o  out  DW  fetch-master read data
m0_ack_o, m0_err_o  out  1 each  fetch-master terminations
m1_*  (same set as m0_*)  data-master port
s_cyc_o, s_stb_o, s_we_o  out  1 each  to ROM
s_adr_o  out  AW  to ROM
s_sel_o  out  4  to ROM
s_dat_o  out  DW  to ROM
s_dat_i  in  DW  ROM read data
s_ack_i  in  1  ROM acknowledge

Behaviour:
- req_k = mk_cyc_i & mk_stb_i.
- Reset, while rst_ni=0 at a clock edge:
  - state=IDLE; last_grant=m1, so m0 wins the first tie.
  - Timeout counter=0.
  - All ack/err outputs 0; s_cyc_o/s_stb_o/s_we_o 0; s_adr_o/s_sel_o/s_dat_o 0; m*_dat_o 0.
- States: IDLE, BUSY0, BUSY1, ERR0, ERR1.
- IDLE:
  - s_* held 0.
  - Only one req_k: grant k. Both: grant the master that is not last_grant. None: stay in IDLE.
  - Granted master has we=1: next state ERRk; the write is never forwarded.
  - Otherwise: next state BUSYk; counter cleared.
- BUSYk:
  - s_cyc/stb/we/adr/sel/dat combinationally follow master k.
  - mk_dat_o = s_dat_i; mk_ack_o = s_ack_i & req_k.
  - Other master: ack=err=0, dat_o=0.
- BUSYk exits (priority order):
  - (1) req_k drops: abort; s_* fall combinationally that cycle; go to IDLE with no termination.
  - (2) s_ack_i=1: ack delivered this cycle; next IDLE; last_grant=k.
  - (3) Counter reaches TIMEOUT-1: mk_err_o=1 this cycle, s_cyc_o/s_stb_o forced 0 this cycle; next IDLE; last_grant=k.
  - (4) Otherwise counter increments.
- ERRk:
  - mk_err_o = req_k for exactly one cycle; s_* stay 0.
  - Next IDLE; last_grant=k.
- IDLE is always entered for at least one cycle between slave cycles. This guarantees the ROM's toggled ack register clears before the next strobe.
- Read latency: request seen in IDLE at cycle 0 → s_stb_o at cycle 1 → ack to master at cycle 2 (ROM acks one cycle after strobe). Sustained rate is one read per 3 cycles.
- ack and err are mutually exclusive and never asserted to a master that is not granted.
- Request arriving during another master's BUSY/ERR: it waits. No starvation: with both masters continuously requesting, grants strictly alternate.
- Mid-operation reset: the next edge enters IDLE; no termination is delivered for the interrupted cycle.

Test Plan:
- m0 reads adr=0x004, ROM word 1 = 0x00000093 → s_stb_o high at cycle 1; m0_ack_o=1 with m0_dat_o=0x00000093 at cycle 2; IDLE at cycle 3.
- m0 and m1 request reads in the same cycle, held for 4 transactions → grants m0,m1,m0,m1; each ack arrives 3 cycles after the previous; no overlapping acks.
- m1 write (we=1, adr=0x010, dat=0xDEADBEEF) → s_cyc_o never rises; m1_err_o=1 for exactly one cycle, 1 cycle after request; m1_ack_o stays 0.
- Slave ack held 0, m0 read pending, TIMEOUT=15 → m0_err_o pulses on the 15th BUSY cycle; s_cyc_o drops that same cycle; a waiting m1 is granted next.
- m0 drops cyc in the BUSY0 cycle before ack → s_cyc_o falls that cycle; no ack/err to m0; a pending m1 request is granted from the following IDLE.
- rst_ni=0 asserted during BUSY1 → after the edge: all outputs 0, state IDLE; after release, the first tie grants m0.
